// File: rtl/pmem_arbiter_n.sv
// N-client arbiter in front of the single physical memory port: latches one client
// request, owns pmem until pmem_resp, then hands the response back to that client.
module pmem_arbiter_n #(
   parameter int NUM_CLIENTS = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 256,
   parameter int RR_MODE     = 0,
   parameter int TIMEOUT_CYC = 0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_CLIENTS-1:0]          cl_read,
   input  logic [NUM_CLIENTS-1:0]          cl_write,
   input  logic [NUM_CLIENTS*ADDR_W-1:0]   cl_addr,
   input  logic [NUM_CLIENTS*DATA_W-1:0]   cl_wdata,
   output logic [NUM_CLIENTS-1:0]          cl_resp,
   output logic [DATA_W-1:0]               cl_rdata,
   output logic                            pmem_read,
   output logic                            pmem_write,
   output logic [ADDR_W-1:0]               pmem_addr,
   output logic [DATA_W-1:0]               pmem_wdata,
   input  logic                            pmem_resp,
   input  logic [DATA_W-1:0]               pmem_rdata,
   output logic [$clog2(NUM_CLIENTS)-1:0]  grant_id,
   output logic                            busy,
   output logic                            timeout_err,
   output logic                            dbg_state
);

   localparam int IDW = $clog2(NUM_CLIENTS);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

   // Handshake: cl_read/cl_write are levels held until the one-cycle cl_resp pulse;
   // a client owns pmem from the cycle after its request is seen in IDLE until pmem_resp.
   state_t              r_state;
   state_t              w_state_next;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_is_write;
   logic [IDW-1:0]      r_gid;
   logic [IDW-1:0]      r_ptr;

   logic [NUM_CLIENTS-1:0] w_req;
   logic                   w_any_req;
   logic                   w_found;
   logic [IDW-1:0]         w_win;
   logic [IDW-1:0]         w_base;
   logic [IDW-1:0]         w_ptr_next;
   logic                   w_grant;

   assign w_req     = cl_read | cl_write;
   assign w_any_req = |w_req;
   assign w_base    = (RR_MODE != 0) ? r_ptr : '0;
   assign w_grant   = (r_state == ST_IDLE) && w_any_req;

   // First requester at or after the base index, wrapping; base is 0 in fixed-priority mode.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int k = 0; k < NUM_CLIENTS; k++) begin
         int idx;
         idx = (int'(w_base) + k) % NUM_CLIENTS;
         if (!w_found && w_req[idx]) begin
            w_found = 1'b1;
            w_win   = IDW'(idx);
         end
      end
   end

   assign w_ptr_next = (w_win == IDW'(NUM_CLIENTS - 1)) ? '0 : w_win + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      busy         = 1'b0;
      cl_resp      = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_any_req) w_state_next = ST_BUSY;
         end
         ST_BUSY: begin
            busy       = 1'b1;
            pmem_read  = ~r_is_write;
            pmem_write = r_is_write;
            if (pmem_resp) begin
               cl_resp[r_gid] = 1'b1;
               w_state_next   = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Write wins over read when a client raises both; pmem sees only the latched copy.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr     <= '0;
         r_wdata    <= '0;
         r_is_write <= 1'b0;
         r_gid      <= '0;
         r_ptr      <= '0;
      end else if (w_grant) begin
         r_addr     <= cl_addr[w_win*ADDR_W +: ADDR_W];
         r_wdata    <= cl_wdata[w_win*DATA_W +: DATA_W];
         r_is_write <= cl_write[w_win];
         r_gid      <= w_win;
         r_ptr      <= w_ptr_next;
      end
   end

   assign pmem_addr  = r_addr;
   assign pmem_wdata = r_wdata;
   assign cl_rdata   = pmem_rdata;
   assign grant_id   = r_gid;
   assign dbg_state  = r_state;

   generate
      if (TIMEOUT_CYC > 0) begin : g_wd
         localparam int CW = $clog2(TIMEOUT_CYC + 1);
         logic [CW-1:0] r_wd_cnt;
         logic          r_timeout;

         // Saturating count of BUSY cycles; the flag is sticky and never aborts the transaction.
         always_ff @(posedge clk) begin
            if (rst) begin
               r_wd_cnt  <= '0;
               r_timeout <= 1'b0;
            end else if (r_state == ST_IDLE) begin
               if (w_any_req) r_wd_cnt <= '0;
            end else begin
               if (r_wd_cnt != CW'(TIMEOUT_CYC)) r_wd_cnt <= r_wd_cnt + 1'b1;
               if (r_wd_cnt >= CW'(TIMEOUT_CYC - 1)) r_timeout <= 1'b1;
            end
         end

         assign timeout_err = r_timeout;
      end else begin : g_no_wd
         assign timeout_err = 1'b0;
      end
   endgenerate

endmodule

// File: tb/tb_pmem_arbiter_n.sv
// Directed bench: a fixed-priority 2-client instance with a 16-cycle watchdog and a
// round-robin 3-client instance, driven by a cycle table plus hand-written sequences.
module tb_pmem_arbiter_n;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // ---------------- instance A: 2 clients, fixed priority, watchdog 16
   logic [1:0]   a_rd, a_wr, a_cl_resp;
   logic [63:0]  a_addr;
   logic [511:0] a_wdata;
   logic         a_presp, a_pread, a_pwrite, a_busy, a_to, a_dbg;
   logic [255:0] a_prdata, a_cl_rdata, a_pwdata;
   logic [31:0]  a_paddr;
   logic [0:0]   a_gid;

   pmem_arbiter_n #(.NUM_CLIENTS(2), .ADDR_W(32), .DATA_W(256), .RR_MODE(0), .TIMEOUT_CYC(16)) u_a (
      .clk(clk), .rst(rst), .cl_read(a_rd), .cl_write(a_wr), .cl_addr(a_addr),
      .cl_wdata(a_wdata), .cl_resp(a_cl_resp), .cl_rdata(a_cl_rdata), .pmem_read(a_pread),
      .pmem_write(a_pwrite), .pmem_addr(a_paddr), .pmem_wdata(a_pwdata), .pmem_resp(a_presp),
      .pmem_rdata(a_prdata), .grant_id(a_gid), .busy(a_busy), .timeout_err(a_to),
      .dbg_state(a_dbg));

   // ---------------- instance B: 3 clients, round-robin, no watchdog
   logic [2:0]   b_rd, b_wr, b_cl_resp;
   logic [95:0]  b_addr;
   logic [767:0] b_wdata;
   logic         b_presp, b_pread, b_pwrite, b_busy, b_to, b_dbg;
   logic [255:0] b_prdata, b_cl_rdata, b_pwdata;
   logic [31:0]  b_paddr;
   logic [1:0]   b_gid;

   pmem_arbiter_n #(.NUM_CLIENTS(3), .ADDR_W(32), .DATA_W(256), .RR_MODE(1), .TIMEOUT_CYC(0)) u_b (
      .clk(clk), .rst(rst), .cl_read(b_rd), .cl_write(b_wr), .cl_addr(b_addr),
      .cl_wdata(b_wdata), .cl_resp(b_cl_resp), .cl_rdata(b_cl_rdata), .pmem_read(b_pread),
      .pmem_write(b_pwrite), .pmem_addr(b_paddr), .pmem_wdata(b_pwdata), .pmem_resp(b_presp),
      .pmem_rdata(b_prdata), .grant_id(b_gid), .busy(b_busy), .timeout_err(b_to),
      .dbg_state(b_dbg));

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  rd;
      logic [1:0]  wr;
      logic [31:0] a0;
      logic [31:0] a1;
      logic [15:0] wd0;
      logic        resp;
      logic [7:0]  rdb;
      logic        e_rd;
      logic        e_wr;
      logic [31:0] e_addr;
      logic [15:0] e_wd;
      logic [1:0]  e_resp;
      logic        e_gid;
      logic        e_busy;
   } vec_t;

   vec_t vecs[17];

   // One round-robin transaction on B: idle cycle, then one BUSY cycle answered at once.
   task automatic b_txn(input logic [2:0] req, input int exp_id, input logic [7:0] rdb);
      logic [31:0] exp_addr;
      logic [2:0]  exp_resp;
      exp_addr = 32'h100 * (exp_id + 1);
      exp_resp = 3'b001 << exp_id;
      @(negedge clk);
      b_rd = req; b_presp = 1'b0;
      #1;
      chk($sformatf("b_idle_busy_%0d", exp_id), b_busy, 1'b0);
      @(negedge clk);
      #1;
      chk($sformatf("b_busy_%0d", exp_id), b_busy, 1'b1);
      chk($sformatf("b_gid_%0d", exp_id), b_gid, exp_id[1:0]);
      chk($sformatf("b_pread_%0d", exp_id), b_pread, 1'b1);
      chk($sformatf("b_paddr_%0d", exp_id), b_paddr, exp_addr);
      b_presp = 1'b1; b_prdata = {32{rdb}};
      #1;
      chk($sformatf("b_cl_resp_%0d", exp_id), b_cl_resp, exp_resp);
      chk($sformatf("b_cl_rdata_%0d", exp_id), b_cl_rdata, {32{rdb}});
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      //          rd     wr     a0       a1       wd0     rsp  rdb   |  rd wr addr     wd      resp   gid busy
      vecs[0]  = '{2'b10, 2'b00, 32'h0,   32'h1040, 16'h0,    1'b0, 8'h00, 1'b0, 1'b0, 32'h0,    16'h0,    2'b00, 1'b0, 1'b0};
      vecs[1]  = '{2'b10, 2'b00, 32'h0,   32'h1040, 16'h0,    1'b0, 8'h00, 1'b1, 1'b0, 32'h1040, 16'h0,    2'b00, 1'b1, 1'b1};
      vecs[2]  = '{2'b10, 2'b00, 32'h0,   32'h1040, 16'h0,    1'b1, 8'hA5, 1'b1, 1'b0, 32'h1040, 16'h0,    2'b10, 1'b1, 1'b1};
      vecs[3]  = '{2'b00, 2'b00, 32'h0,   32'h0,    16'h0,    1'b0, 8'h00, 1'b0, 1'b0, 32'h1040, 16'h0,    2'b00, 1'b1, 1'b0};
      vecs[4]  = '{2'b11, 2'b00, 32'h2000, 32'h3000, 16'h0,   1'b0, 8'h00, 1'b0, 1'b0, 32'h1040, 16'h0,    2'b00, 1'b1, 1'b0};
      vecs[5]  = '{2'b11, 2'b00, 32'h2000, 32'h3000, 16'h0,   1'b0, 8'h00, 1'b1, 1'b0, 32'h2000, 16'h0,    2'b00, 1'b0, 1'b1};
      vecs[6]  = '{2'b11, 2'b00, 32'h2000, 32'h3000, 16'h0,   1'b1, 8'h5A, 1'b1, 1'b0, 32'h2000, 16'h0,    2'b01, 1'b0, 1'b1};
      vecs[7]  = '{2'b11, 2'b00, 32'h2000, 32'h3000, 16'h0,   1'b0, 8'h00, 1'b0, 1'b0, 32'h2000, 16'h0,    2'b00, 1'b0, 1'b0};
      vecs[8]  = '{2'b11, 2'b00, 32'h2000, 32'h3000, 16'h0,   1'b0, 8'h00, 1'b1, 1'b0, 32'h2000, 16'h0,    2'b00, 1'b0, 1'b1};
      vecs[9]  = '{2'b11, 2'b00, 32'h2000, 32'h3000, 16'h0,   1'b1, 8'hC3, 1'b1, 1'b0, 32'h2000, 16'h0,    2'b01, 1'b0, 1'b1};
      vecs[10] = '{2'b00, 2'b00, 32'h0,   32'h0,    16'h0,    1'b0, 8'h00, 1'b0, 1'b0, 32'h2000, 16'h0,    2'b00, 1'b0, 1'b0};
      vecs[11] = '{2'b01, 2'b01, 32'h40,  32'h0,    16'h1234, 1'b0, 8'h00, 1'b0, 1'b0, 32'h2000, 16'h0,    2'b00, 1'b0, 1'b0};
      vecs[12] = '{2'b01, 2'b01, 32'h40,  32'h0,    16'h1234, 1'b0, 8'h00, 1'b0, 1'b1, 32'h40,   16'h1234, 2'b00, 1'b0, 1'b1};
      vecs[13] = '{2'b01, 2'b01, 32'h80,  32'h0,    16'h5555, 1'b0, 8'h00, 1'b0, 1'b1, 32'h40,   16'h1234, 2'b00, 1'b0, 1'b1};
      vecs[14] = '{2'b01, 2'b01, 32'h80,  32'h0,    16'h5555, 1'b1, 8'h3C, 1'b0, 1'b1, 32'h40,   16'h1234, 2'b01, 1'b0, 1'b1};
      vecs[15] = '{2'b00, 2'b00, 32'h0,   32'h0,    16'h0,    1'b0, 8'h00, 1'b0, 1'b0, 32'h40,   16'h1234, 2'b00, 1'b0, 1'b0};
      vecs[16] = '{2'b00, 2'b00, 32'h0,   32'h0,    16'h0,    1'b1, 8'h77, 1'b0, 1'b0, 32'h40,   16'h1234, 2'b00, 1'b0, 1'b0};

      rst = 1'b1;
      a_rd = '0; a_wr = '0; a_addr = '0; a_wdata = '0; a_presp = 1'b0; a_prdata = '0;
      b_rd = '0; b_wr = '0; b_addr = {32'h300, 32'h200, 32'h100}; b_wdata = '0;
      b_presp = 1'b0; b_prdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_busy", a_busy, 1'b0);
      chk("reset_pread", a_pread, 1'b0);
      chk("reset_pwrite", a_pwrite, 1'b0);
      chk("reset_paddr", a_paddr, 32'h0);
      chk("reset_gid", a_gid, 1'b0);
      chk("reset_timeout", a_to, 1'b0);
      chk("reset_b_busy", b_busy, 1'b0);

      // single read, fixed-priority starvation, read+write precedence, stray resp in IDLE
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         a_rd = vecs[i].rd; a_wr = vecs[i].wr;
         a_addr = {vecs[i].a1, vecs[i].a0};
         a_wdata = {256'h0, 240'h0, vecs[i].wd0};
         a_presp = vecs[i].resp; a_prdata = {32{vecs[i].rdb}};
         #1;
         chk($sformatf("row%0d_pread", i), a_pread, vecs[i].e_rd);
         chk($sformatf("row%0d_pwrite", i), a_pwrite, vecs[i].e_wr);
         chk($sformatf("row%0d_paddr", i), a_paddr, vecs[i].e_addr);
         chk($sformatf("row%0d_pwdata", i), a_pwdata, {240'h0, vecs[i].e_wd});
         chk($sformatf("row%0d_cl_resp", i), a_cl_resp, vecs[i].e_resp);
         chk($sformatf("row%0d_gid", i), a_gid, vecs[i].e_gid);
         chk($sformatf("row%0d_busy", i), a_busy, vecs[i].e_busy);
         chk($sformatf("row%0d_dbg", i), a_dbg, vecs[i].e_busy);
         chk($sformatf("row%0d_cl_rdata", i), a_cl_rdata, {32{vecs[i].rdb}});
      end
      chk("table_timeout", a_to, 1'b0);

      // watchdog: pmem_resp withheld, flag after 16 BUSY cycles, sticky past the response
      @(negedge clk);
      a_rd = 2'b01; a_wr = 2'b00; a_addr = {32'h0, 32'h500}; a_presp = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         #1;
         if (k == 1) chk("wd_busy_start", a_busy, 1'b1);
         if (k == 16) chk("wd_before_limit", a_to, 1'b0);
      end
      @(negedge clk);
      #1;
      chk("wd_at_limit", a_to, 1'b1);
      chk("wd_still_busy", a_busy, 1'b1);
      @(negedge clk);
      a_presp = 1'b1; a_prdata = {32{8'h99}};
      #1;
      chk("wd_cl_resp", a_cl_resp, 2'b01);
      chk("wd_cl_rdata", a_cl_rdata, {32{8'h99}});
      @(negedge clk);
      a_presp = 1'b0; a_rd = 2'b00;
      #1;
      chk("wd_idle", a_busy, 1'b0);
      chk("wd_sticky", a_to, 1'b1);

      // reset in the middle of a transaction, then a stray pmem_resp
      @(negedge clk);
      a_rd = 2'b10; a_addr = {32'h7000, 32'h0};
      @(negedge clk);
      #1;
      chk("mid_busy", a_busy, 1'b1);
      chk("mid_gid", a_gid, 1'b1);
      chk("mid_paddr", a_paddr, 32'h7000);
      rst = 1'b1; a_rd = 2'b00;
      @(negedge clk);
      rst = 1'b0; a_presp = 1'b1;
      #1;
      chk("rst_busy", a_busy, 1'b0);
      chk("rst_pread", a_pread, 1'b0);
      chk("rst_paddr", a_paddr, 32'h0);
      chk("rst_pwdata", a_pwdata, 256'h0);
      chk("rst_gid", a_gid, 1'b0);
      chk("rst_timeout", a_to, 1'b0);
      chk("rst_stray_resp", a_cl_resp, 2'b00);
      @(negedge clk);
      a_presp = 1'b0;
      #1;
      chk("rst_stray_no_start", a_busy, 1'b0);

      // round-robin: all three request continuously, then pointer skip and wrap
      for (int t = 0; t < 6; t++) begin
         b_txn(3'b111, t % 3, 8'(t + 1));
      end
      b_txn(3'b001, 0, 8'hE0);
      b_txn(3'b101, 2, 8'hE1);
      b_txn(3'b110, 1, 8'hE2);
      @(negedge clk);
      b_rd = 3'b000; b_presp = 1'b0;
      #1;
      chk("b_final_idle", b_busy, 1'b0);
      chk("b_no_timeout", b_to, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
